// File: rtl/neuron_activation.sv
// Activation stage behind the MAC accumulator.
// Takes the dot product as the accumulator delta per vector, adds bias, applies ReLU, shifts, saturates, and buffers two results.
module neuron_activation #(
    parameter int unsigned data_width = 8,
    parameter int unsigned SHIFT      = 4,
    localparam int unsigned ACC_W     = 2 * data_width + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ACC_W-1:0]      acc_in,
    input  logic                  acc_valid,
    input  logic                  acc_last,
    input  logic [ACC_W-1:0]      bias,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           beat_count,
    output logic                  overrun
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0]      base_q, base_d;
    logic [15:0]           beat_q, beat_d;
    logic [SUM_W-1:0]      s1_sum_q, s1_sum_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [data_width-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;

    logic                  end_beat_c;
    logic                  s1_adv_c;
    logic [ACC_W-1:0]      diff_c;
    logic [SUM_W-1:0]      sum_c;
    logic [SUM_W-1:0]      shifted_c;
    logic [data_width-1:0] act_c;

    // Dot product = accumulator delta since the previous vector end, sign-extended one bit before the bias add
    always_comb begin
        end_beat_c = acc_valid & acc_last;
        s1_adv_c   = s1_valid_q & (~out_valid_q | out_ready);
        diff_c     = acc_in - base_q;
        sum_c      = SUM_W'({diff_c[ACC_W-1], diff_c}) + SUM_W'({bias[ACC_W-1], bias});
    end

    // ReLU, shift, then clamp to the unsigned output range
    always_comb begin
        shifted_c = s1_sum_q >> SHIFT;
        act_c     = '0;
        if (!s1_sum_q[SUM_W-1]) begin
            if (|shifted_c[SUM_W-1:data_width]) begin
                act_c = '1;
            end else begin
                act_c = shifted_c[data_width-1:0];
            end
        end
    end

    always_comb begin
        base_d      = base_q;
        beat_d      = beat_q;
        s1_sum_d    = s1_sum_q;
        s1_valid_d  = s1_valid_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (acc_valid && !acc_last && beat_q != 16'hFFFF) begin
            beat_d = beat_q + 16'd1;
        end

        if (s1_adv_c) begin
            s1_valid_d = 1'b0;
        end

        // Base tracking continues even when the result itself is dropped
        if (end_beat_c) begin
            base_d = acc_in;
            beat_d = '0;
            if (!s1_valid_q || s1_adv_c) begin
                s1_sum_d   = sum_c;
                s1_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (s1_adv_c) begin
            out_d       = act_c;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q      <= '0;
            beat_q      <= '0;
            s1_sum_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            base_q      <= base_d;
            beat_q      <= beat_d;
            s1_sum_q    <= s1_sum_d;
            s1_valid_q  <= s1_valid_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data   = out_q;
    assign out_valid  = out_valid_q;
    assign beat_count = beat_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_neuron_activation.sv
// Directed bench for neuron_activation: delta, bias, ReLU, saturation, wrap-around, backpressure/overrun and async reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_neuron_activation;

    localparam int unsigned DW    = 8;
    localparam int unsigned ACC_W = 2 * DW + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [ACC_W-1:0] acc_in;
    logic             acc_valid;
    logic             acc_last;
    logic [ACC_W-1:0] bias;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      beat_count;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    neuron_activation #(.data_width(DW), .SHIFT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .acc_last   (acc_last),
        .bias       (bias),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .beat_count (beat_count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one beat for a single cycle, then return inputs to idle
    task automatic drive_beat(input logic [ACC_W-1:0] acc, input logic last, input int b);
        acc_in    = acc;
        acc_last  = last;
        acc_valid = 1'b1;
        bias      = ACC_W'(b);
        @(negedge clk);
        acc_valid = 1'b0;
        acc_last  = 1'b0;
        bias      = '0;
    endtask

    // Bounded wait for a result, then compare it
    task automatic expect_out(input string tag, input int exp);
        int n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_data), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        acc_in    = '0;
        acc_valid = 1'b0;
        acc_last  = 1'b0;
        bias      = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Vector 1: 10, 30, 50(last) -> 50>>4 = 3, valid exactly two edges after the end beat
        drive_beat(17'd10, 1'b0, 0);
        check("v1_beat1", 32'(beat_count), 32'd1);
        drive_beat(17'd30, 1'b0, 0);
        check("v1_beat2", 32'(beat_count), 32'd2);
        drive_beat(17'd50, 1'b1, 0);
        check("v1_beat_clr", 32'(beat_count), 32'd0);
        check("v1_not_yet_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("v1_valid_lat2", 32'(out_valid), 32'd1);
        check("v1_data", 32'(out_data), 32'd3);
        @(negedge clk);
        check("v1_valid_drop", 32'(out_valid), 32'd0);

        // Vector 2: 60, 90(last), bias -8 -> diff 40, sum 32 -> 2
        drive_beat(17'd60, 1'b0, 0);
        drive_beat(17'd90, 1'b1, -8);
        expect_out("v2_data", 2);

        // ReLU: diff 16, bias -100
        drive_beat(17'd106, 1'b1, -100);
        expect_out("relu_data", 0);

        // Saturation: diff 20000 -> 1250 -> 255
        drive_beat(17'd20106, 1'b1, 0);
        expect_out("sat_data", 255);

        // Move base to 0x1FFF0 (delta is negative as signed 17-bit), then wrap to 0x10
        drive_beat(17'h1FFF0, 1'b1, 0);
        expect_out("neg_delta_data", 0);
        drive_beat(17'h00010, 1'b1, 0);
        expect_out("wrap_data", 2);

        // Backpressure: three back-to-back vectors of diff 16, 32, 48; third is dropped
        out_ready = 1'b0;
        drive_beat(17'h00020, 1'b1, 0);
        drive_beat(17'h00040, 1'b1, 0);
        drive_beat(17'h00070, 1'b1, 0);
        @(negedge clk);
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_first", 32'(out_data), 32'd1);
        @(negedge clk);
        check("bp_hold", 32'(out_data), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second", 32'(out_data), 32'd2);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Base must be the dropped vector's value 0x70: diff 80 -> 5
        drive_beat(17'h000C0, 1'b1, 0);
        expect_out("post_drop_data", 5);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Pending result plus partial vector, then async reset between edges
        out_ready = 1'b0;
        drive_beat(17'h000D0, 1'b1, 0);
        drive_beat(17'h000E0, 1'b0, 0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_beat", 32'(beat_count), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_beat", 32'(beat_count), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Base restarts at 0: 0x30 -> 48>>4 = 3
        drive_beat(17'h00030, 1'b1, 0);
        expect_out("post_rst_data", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_activation.md
# neuron_activation

Post-processing stage directly downstream of the `mac_unit` accumulator. It turns the running, never-cleared accumulator value into one activated neuron output per vector. On each vector-end strobe it takes the vector's dot product as the difference from the previous end-of-vector snapshot. It then adds a signed bias, applies ReLU, right-shifts and saturates to an unsigned `data_width` result, and presents it on a valid/ready output for the next layer's operand feeder.

## Interface
Parameters:
- `data_width`, 8: operand width of the upstream MAC; output width.
- `SHIFT`, 4: arithmetic right shift applied after ReLU (0 ≤ SHIFT < 2*data_width).
- ACC_W (derived, not overridable) = 2*data_width+1.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `acc_in`  in  ACC_W  accumulator value from the MAC, unsigned, modulo 2^ACC_W.
- `acc_valid`  in  1  `acc_in` is a fresh post-accumulate value this cycle.
- `acc_last`  in  1  qualifies `acc_valid`: this value ends the current vector.
- `bias`  in  ACC_W  signed two's-complement bias, sampled with the `acc_last` beat.
- `out_data`  out  data_width  activated neuron value.
- `out_valid`  out  1  `out_data` holds an unconsumed result.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `beat_count`  out  16  beats in the current vector so far; saturates at 0xFFFF.
- `overrun`  out  1  sticky; a result was dropped. Cleared only by reset.

## Operation
- Base register `base` (ACC_W bits) holds the accumulator value at the previous vector end. It resets to 0, matching the MAC reset value.
- `acc_valid & !acc_last`: `beat_count` increments by 1 and saturates.
- `acc_valid & acc_last` (end beat):
  - diff = (acc_in − base) mod 2^ACC_W, interpreted as signed ACC_W.
  - sum = diff + bias, computed at ACC_W+1 bits signed, so no overflow is possible.
  - `base` <= `acc_in` and `beat_count` <= 0.
  - These updates happen unconditionally, including when the result is dropped.
- Stage 1 register S1 captures `sum` with `s1_valid` = 1.
- Stage 2, applied as S1 moves to the output register:
  - r = (sum < 0) ? 0 : sum >>> SHIFT.
  - `out_data` = (r > 2^data_width−1) ? 2^data_width−1 : r[data_width-1:0].
- Flow control:
  - S1 advances when `!out_valid | out_ready`.
  - If S1 is occupied and cannot advance when a new end beat arrives, the new result is discarded and `overrun` <= 1. The S1 contents and `base` tracking remain correct.
  - An end beat arriving while S1 advances in the same cycle is accepted with no drop.
- `out_valid` drops after a handshake (`out_valid & out_ready`) unless S1 advances in the same cycle.
- `out_data` holds stable while `out_valid & !out_ready`.
- `acc_last` without `acc_valid` is ignored.
- Reset mid-vector: `base`, S1, the output register, `beat_count` and `overrun` clear immediately. Any partial vector is lost. `base` = 0 must coincide with the MAC being reset together with this block.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `beat_count`=0, `overrun`=0, `base`=0, `s1_valid`=0.
- Latency with no backpressure: end beat at edge T; S1 valid after T; `out_valid`=1 after edge T+1. That is 2 cycles.
- Throughput: one result per cycle sustained when `out_ready`=1.
- Buffering: 2 results total (S1 plus the output register) before a drop.
- `beat_count` is registered and reads the updated value the cycle after the beat.
- No combinational path from `out_ready` to `out_valid` or `out_data`.

## Test plan
- Reset then beats with acc_in = 10, 30, 50(last), bias=0, SHIFT=4, `out_ready`=1 → `out_data`=3 (50>>4), `out_valid` exactly 2 cycles after the last beat, `beat_count` 1, 2, then 0.
- Second vector with acc_in = 60, 90(last), bias=−8 → diff 40, sum 32, `out_data`=2. This confirms the base snapshot of 50.
- Negative result: the vector diff = 16 with bias=−100 → `out_data`=0 (ReLU).
- Saturation: diff = 20000 with bias=0, SHIFT=4 → 1250 clamps to `out_data`=255.
- Wrap-around: base=0x1FFF0, acc_in=0x00010(last) → diff=0x20 (mod 2^17), `out_data`=2.
- Backpressure: hold `out_ready`=0 and issue 3 single-beat vectors of diffs 16, 32, 48.
  - Results 1 and 2 are retained; the third is dropped and `overrun`=1.
  - Releasing `out_ready` yields 1 then 2 on consecutive cycles.
  - A following vector's diff is still computed against base = the third vector's value.
  - Asserting reset mid-vector clears `overrun`, `out_valid` and `beat_count` within the same cycle.
